fifo_rd_stream: RTL
===================

Name: fifo_rd_stream

Overview:
- Read-side consumer of the async FIFO, clocked in the read domain.
- Drives r_en into the read pointer handler and captures memory read data, which arrives one cycle after r_en.
- Presents the data downstream as a valid/ready stream through a 3-entry prefetch buffer, so that 1 word/cycle throughput is sustained despite the memory read latency.
- Optionally reports the FIFO fill level by Gray-decoding the synchronised write pointer.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and m_data.
- PTR_WIDTH, 3, FIFO address width; pointers are PTR_WIDTH+1 bits.

Ports:
- rclk  in  1  read-domain clock.
- rrst_n  in  1  reset, asynchronous, active-low.
- empty  in  1  registered empty flag from the read pointer handler.
- r_en  out  1  read request to the pointer handler and memory.
- rdata  in  DATA_WIDTH  memory read data, valid the cycle after a read is accepted.
- m_valid  out  1  downstream word available.
- m_data  out  DATA_WIDTH  downstream word.
- m_ready  in  1  downstream accept.
- g_wptr_sync  in  PTR_WIDTH+1  synchronised Gray write pointer (RD_LEVEL_EN only).
- b_rptr  in  PTR_WIDTH+1  binary read pointer (RD_LEVEL_EN only).
- rd_level  out  PTR_WIDTH+1  FIFO fill level (RD_LEVEL_EN only).

Behaviour:
- Reset (async, rrst_n=0):
  - Buffer emptied; occ=0; inflight=0.
  - m_valid=0, m_data=0, rd_level=0. r_en=0 follows combinationally, since empty is also held 1 by the handler's reset.
- Read accept:
  - r_en = !empty && (occ + inflight) < 3. Combinational from registers only; there is no m_ready-to-r_en path.
  - A read is accepted in cycle N when r_en=1 and empty=0.
  - inflight is set to 1 at the end of cycle N, otherwise cleared.
- Capture: in cycle N+1, with inflight=1, rdata is written into the buffer at the end of the cycle.
- Buffer:
  - 3-entry circular buffer with 2-bit wrapping pointers (0,1,2,0) and an occ counter 0..3.
  - m_valid = occ != 0.
  - m_data = head entry, registered in the buffer (no rdata passthrough).
- Handshake:
  - Pop happens when m_valid && m_ready; the head advances at the clock edge.
  - m_data is held stable while m_valid && !m_ready.
- Simultaneous pop and capture: occ is unchanged and both pointers advance.
- Latency: first word, with empty falling in cycle N gives r_en in N, capture at end of N+1, m_valid=1 in N+2.
- Throughput: with m_ready held 1 and the FIFO non-empty, steady state is occ=1, inflight=1, r_en=1 every cycle, giving one word per cycle.
- Overflow is impossible by construction (occ+inflight<=3). An assertion flags any capture when occ=3.
- Backpressure: with m_ready=0, exactly 3 words are prefetched and r_en then stays 0 until a pop.
- Reset mid-operation: buffered and in-flight words are discarded; no m_valid glitch after reset release.

Optional Feature:
- Macro: RD_LEVEL_EN.
- Defined:
  - g_wptr_sync is Gray-to-binary converted.
  - rd_level is registered each cycle as (bin_wptr - b_rptr) mod 2^(PTR_WIDTH+1), so it ranges 0..2^PTR_WIDTH.
  - The value lags the true level by 1 cycle; it excludes prefetched words.
- Undefined: the g_wptr_sync, b_rptr and rd_level ports and the related logic are absent.

Decomposition:
- Shared package holds:
  - RD_BUF_DEPTH=3 constant.
  - gray2bin function, parameterised by width and also reused by the write-side level logic.
- Sub-module rd_prefetch_buf: 3-entry buffer with push/pop/occ. The top block holds the r_en/inflight control and the level logic.

Test Plan:
- Reset, then 3 words 0xA1,0xA2,0xA3 written (empty falls in cycle 10), m_ready=1 → r_en in cycles 10..12; m_valid from cycle 12; m_data A1,A2,A3 on consecutive cycles.
- m_ready=0, FIFO holding 6 words → exactly 3 r_en pulses, occ=3, r_en=0 thereafter. Then m_ready=1 → remaining 3 words in order, no loss or duplication.
- Random m_ready (50%) over 1000 words → in-order data, no overflow assertion, m_data stable while stalled.
- FIFO drains to empty with occ=1 and pop in the same cycle → m_valid falls next cycle; r_en never asserted while empty=1.
- rrst_n pulsed low with occ=2, inflight=1 → m_valid=0 immediately; after release no stale word appears.
- RD_LEVEL_EN, PTR_WIDTH=3: g_wptr_sync=Gray(5)=0111, b_rptr=2 → rd_level=3 one cycle later. Wrap case: bin_wptr=1, b_rptr=14 → rd_level=3.

Source files
------------

// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the async FIFO read-side consumer.
// Holds the prefetch buffer depth and the Gray-to-binary helper, which the
// write-side level logic also uses.
package fifo_rd_stream_pkg;

    localparam int RD_BUF_DEPTH = 3;
    localparam int G2B_MAX_W    = 32;

    // Gray-to-binary conversion for any pointer width up to G2B_MAX_W.
    // Callers zero-extend their Gray code and truncate the result. Leading
    // zeros in a Gray code decode to leading zeros, so this is exact for
    // every narrower width.
    function automatic logic [G2B_MAX_W-1:0] gray2bin(input logic [G2B_MAX_W-1:0] g);
        logic [G2B_MAX_W-1:0] b;
        b[G2B_MAX_W-1] = g[G2B_MAX_W-1];
        for (int i = G2B_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_rd_prefetch_buf.sv
// rd_prefetch_buf: 3-entry circular buffer between the FIFO memory read port
// and the downstream stream.
// The head entry comes straight from the storage registers, so the
// downstream data never passes through combinationally from the memory.
module rd_prefetch_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [1:0]            occ,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] mem_q [RD_BUF_DEPTH];
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [1:0]            occ_q, occ_d;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(RD_BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // Next-state for the pointers and occupancy. When a push and a pop
    // happen together, both pointers advance and occ stays the same.
    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        occ_d    = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + 2'd1;
        end else if (!push && pop) begin
            occ_d = occ_q - 2'd1;
        end
    end

    // Pointer, occupancy and storage registers; reset discards every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            occ_q    <= 2'd0;
            for (int i = 0; i < RD_BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
            end
        end
    end

    assign occ  = occ_q;
    assign head = mem_q[rd_ptr_q];

    // The read-request gating keeps occ+inflight <= 3, so a capture into a
    // full buffer means that gating is broken.
    no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && occ_q == 2'(RD_BUF_DEPTH)));

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-domain consumer of the async FIFO.
// Issues r_en to the read pointer handler, captures memory data one cycle
// after each accepted read, and presents it as a valid/ready stream through
// a 3-entry prefetch buffer, sustaining one word per cycle.
// Optional fill-level reporting is built when RD_LEVEL_EN is defined.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 3
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  empty,
    output logic                  r_en,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
`ifdef RD_LEVEL_EN
    ,
    input  logic [PTR_WIDTH:0]    g_wptr_sync,
    input  logic [PTR_WIDTH:0]    b_rptr,
    output logic [PTR_WIDTH:0]    rd_level
`endif
);

    if (PTR_WIDTH < 1 || PTR_WIDTH >= G2B_MAX_W) begin : g_bad_ptr_width
        $error("fifo_rd_stream: PTR_WIDTH out of range");
    end

    logic       inflight_q, inflight_d;
    logic [1:0] occ;
    logic       pop;

    // Request only when the buffer can absorb every word already requested.
    // This depends on registers alone, so m_ready never reaches r_en.
    assign r_en       = !empty && ({1'b0, occ} + {2'b00, inflight_q}) < 3'(RD_BUF_DEPTH);
    assign inflight_d = r_en;
    assign m_valid    = (occ != 2'd0);
    assign pop        = m_valid && m_ready;

    // Track the read issued last cycle, whose data arrives on rdata now.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    rd_prefetch_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk   (rclk),
        .rst_n (rrst_n),
        .push  (inflight_q),
        .wdata (rdata),
        .pop   (pop),
        .occ   (occ),
        .head  (m_data)
    );

`ifdef RD_LEVEL_EN
    localparam int PW = PTR_WIDTH + 1;

    logic [PTR_WIDTH:0] bin_wptr;
    logic [PTR_WIDTH:0] rd_level_q, rd_level_d;

    assign bin_wptr   = PW'(gray2bin({{(G2B_MAX_W-PW){1'b0}}, g_wptr_sync}));
    assign rd_level_d = bin_wptr - b_rptr;

    // Level register: FIFO words not yet read, lagging by one cycle and not
    // counting words already held in the prefetch buffer.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rd_level_q <= '0;
        end else begin
            rd_level_q <= rd_level_d;
        end
    end

    assign rd_level = rd_level_q;
`endif

endmodule
